// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel tick scheduler sharing one base prescaler
// Optional square-wave outputs: define TICK_SCHED_SQUARE_EN.
module tick_scheduler #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int PRESCALE = 1
) (
    input  logic                   cLocK,
    input  logic                   Reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [DW-1:0]          cfg_ratio,
    input  logic                   cfg_en,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         ch_active
`ifdef TICK_SCHED_SQUARE_EN
    ,
    output logic [NCH-1:0]         sq
`endif
);

    localparam int CW = $clog2(NCH);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   pre;
    logic [DW-1:0]   cnt   [NCH];
    logic [DW-1:0]   ratio [NCH];
    logic [CW-1:0]   l_ch;
    logic [DW-1:0]   l_ratio;
    logic            l_en;
    logic            base;
    logic [NCH-1:0]  wr;
    logic [NCH-1:0]  act_upd;

    assign cfg_ready = (state != UPDATE);
    assign base      = (pre == PW'(PRESCALE - 1));

    // Channel enable vector as it will look after the pending write lands.
    always_comb begin
        wr      = '0;
        act_upd = ch_active;
        for (int i = 0; i < NCH; i++) begin
            if (state == UPDATE && l_ch == CW'(i)) begin
                wr[i]      = 1'b1;
                act_upd[i] = l_en;
            end
        end
    end

    always_ff @(posedge cLocK) begin
        if (!Reset) begin
            state     <= IDLE;
            pre       <= '0;
            l_ch      <= '0;
            l_ratio   <= '0;
            l_en      <= 1'b0;
            tick      <= '0;
            ch_active <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]   <= '0;
                ratio[i] <= '0;
            end
`ifdef TICK_SCHED_SQUARE_EN
            sq        <= '0;
`endif
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (cfg_valid) begin
                        l_ch    <= cfg_ch;
                        l_ratio <= cfg_ratio;
                        l_en    <= cfg_en;
                        state   <= UPDATE;
                    end
                end
                UPDATE:  state <= (|act_upd) ? RUN : IDLE;
                default: state <= IDLE;
            endcase

            // The prescaler only runs while some channel is live, so a start
            // from IDLE always begins at phase 0.
            if (!(|ch_active) || (state == UPDATE && !(|act_upd)))
                pre <= '0;
            else if (base)
                pre <= '0;
            else
                pre <= pre + PW'(1);

            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
                if (wr[i]) begin
                    ratio[i]     <= l_ratio;
                    cnt[i]       <= '0;
                    ch_active[i] <= l_en;
`ifdef TICK_SCHED_SQUARE_EN
                    if (!l_en)
                        sq[i] <= 1'b0;
`endif
                end else if (ch_active[i] && base) begin
                    if (cnt[i] == ratio[i]) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
`ifdef TICK_SCHED_SQUARE_EN
                        sq[i]   <= ~sq[i];
`endif
                    end else begin
                        cnt[i] <= cnt[i] + DW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler
module tb_tick_scheduler;

    logic cLocK = 1'b0;
    always #5 cLocK = ~cLocK;

    logic       a_rst = 1'b0, a_valid = 1'b0, a_ready, a_en = 1'b0;
    logic [2:0] a_ch = '0;
    logic [7:0] a_ratio = '0;
    logic [4:0] a_tick, a_act;
`ifdef TICK_SCHED_SQUARE_EN
    logic [4:0] a_sq;
`endif

    logic       b_rst = 1'b0, b_valid = 1'b0, b_ready, b_en = 1'b0;
    logic [1:0] b_ch = '0;
    logic [7:0] b_ratio = '0;
    logic [3:0] b_tick, b_act;

    tick_scheduler #(.NCH(5), .DW(8), .PRESCALE(1)) dut_a (
        .cLocK(cLocK), .Reset(a_rst), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_ch(a_ch), .cfg_ratio(a_ratio), .cfg_en(a_en),
        .tick(a_tick), .ch_active(a_act)
`ifdef TICK_SCHED_SQUARE_EN
        , .sq(a_sq)
`endif
    );

    tick_scheduler #(.NCH(4), .DW(8), .PRESCALE(4)) dut_b (
        .cLocK(cLocK), .Reset(b_rst), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_ch(b_ch), .cfg_ratio(b_ratio), .cfg_en(b_en),
        .tick(b_tick), .ch_active(b_act)
`ifdef TICK_SCHED_SQUARE_EN
        , .sq()
`endif
    );

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [2:0] ch;
        logic [7:0] r;
        logic       en;
        logic [4:0] tk;
        logic [4:0] act;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic rst_n, logic v, logic [2:0] ch, logic [7:0] r, logic en,
                                logic [4:0] tk, logic [4:0] act, logic rdy);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.ch = ch; t.r = r; t.en = en;
        t.tk = tk; t.act = act; t.rdy = rdy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_row(input logic [4:0] tk, input logic [4:0] act);
        tbl.push_back(mk(1, 0, 0, 0, 0, tk, act, 1));
    endtask

    initial begin
        // Reset held low with a pending request: nothing may be applied.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 5'b0, 5'b0, 1));
        // ch0 R=3, PRESCALE=1: ticks after E5, E9, E13.
        tbl.push_back(mk(1, 1, 0, 3, 1, 5'b0, 5'b0, 0));           // E0
        idle_row(5'b0, 5'b00001);                                   // E1
        for (int i = 0; i < 3; i++) idle_row(5'b0, 5'b00001);       // E2-E4
        idle_row(5'b00001, 5'b00001);                               // E5
        for (int i = 0; i < 3; i++) idle_row(5'b0, 5'b00001);       // E6-E8
        idle_row(5'b00001, 5'b00001);                               // E9
        // cfg_ch beyond NCH is accepted but changes nothing.
        tbl.push_back(mk(1, 1, 5, 9, 0, 5'b0, 5'b00001, 0));        // E10
        tbl.push_back(mk(1, 1, 5, 9, 0, 5'b0, 5'b00001, 1));        // E11
        tbl.push_back(mk(1, 1, 1, 0, 1, 5'b0, 5'b00001, 0));        // E12
        idle_row(5'b00001, 5'b00011);                               // E13
        for (int i = 0; i < 3; i++) idle_row(5'b00010, 5'b00011);   // E14-E16
        tbl.push_back(mk(1, 1, 1, 0, 0, 5'b00011, 5'b00011, 0));    // E17
        idle_row(5'b0, 5'b00001);                                   // E18
        tbl.push_back(mk(1, 1, 0, 3, 0, 5'b0, 5'b00001, 0));        // E19
        idle_row(5'b0, 5'b0);                                       // E20
        idle_row(5'b0, 5'b0);                                       // E21
        // ch0 R=2; ch2 written as ch0 fires, then ch0 rewritten at its firing edge.
        tbl.push_back(mk(1, 1, 0, 2, 1, 5'b0, 5'b0, 0));            // F0
        for (int i = 0; i < 3; i++) idle_row(5'b0, 5'b00001);       // F1-F3
        idle_row(5'b00001, 5'b00001);                               // F4
        idle_row(5'b0, 5'b00001);                                   // F5
        tbl.push_back(mk(1, 1, 2, 1, 1, 5'b0, 5'b00001, 0));        // F6
        idle_row(5'b00001, 5'b00101);                               // F7
        idle_row(5'b0, 5'b00101);                                   // F8
        tbl.push_back(mk(1, 1, 0, 2, 1, 5'b00100, 5'b00101, 0));    // F9
        idle_row(5'b0, 5'b00101);                                   // F10
        idle_row(5'b00100, 5'b00101);                               // F11
        idle_row(5'b0, 5'b00101);                                   // F12
        idle_row(5'b00101, 5'b00101);                               // F13
        // Reset landing on the UPDATE cycle discards the pending write.
        tbl.push_back(mk(1, 1, 1, 0, 1, 5'b0, 5'b00101, 0));        // F14
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b0, 5'b0, 1));            // F15
        idle_row(5'b0, 5'b0);                                       // F16

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge cLocK);
            a_rst = tbl[i].rst_n; a_valid = tbl[i].v; a_ch = tbl[i].ch;
            a_ratio = tbl[i].r; a_en = tbl[i].en;
            @(posedge cLocK);
            #1;
            chk($sformatf("a_tick[%0d]", i), 32'(a_tick), 32'(tbl[i].tk));
            chk($sformatf("a_active[%0d]", i), 32'(a_act), 32'(tbl[i].act));
            chk($sformatf("a_ready[%0d]", i), 32'(a_ready), 32'(tbl[i].rdy));
        end

        // PRESCALE=4: ch1 R=1 (period 8), reprogrammed to R=0 at E12, disabled
        // at E30, then ch0 R=0 restarted from IDLE at E33.
        @(negedge cLocK); b_rst = 1'b0;
        @(negedge cLocK); b_rst = 1'b1;
        for (int k = 0; k <= 42; k++) begin
            logic [3:0] etk, eact;
            logic       erdy;
            @(negedge cLocK);
            b_valid = 1'b0;
            case (k)
                0:  begin b_valid = 1'b1; b_ch = 2'd1; b_ratio = 8'd1; b_en = 1'b1; end
                12: begin b_valid = 1'b1; b_ch = 2'd1; b_ratio = 8'd0; b_en = 1'b1; end
                30: begin b_valid = 1'b1; b_ch = 2'd1; b_ratio = 8'd0; b_en = 1'b0; end
                33: begin b_valid = 1'b1; b_ch = 2'd0; b_ratio = 8'd0; b_en = 1'b1; end
                default: ;
            endcase
            @(posedge cLocK);
            #1;
            etk  = '0;
            etk[1] = (k == 9) || (k == 17) || (k == 21) || (k == 25) || (k == 29);
            etk[0] = (k == 38) || (k == 42);
            eact = '0;
            eact[1] = (k >= 1) && (k <= 30);
            eact[0] = (k >= 34);
            erdy = !((k == 0) || (k == 12) || (k == 30) || (k == 33));
            chk($sformatf("b_tick[%0d]", k), 32'(b_tick), 32'(etk));
            chk($sformatf("b_active[%0d]", k), 32'(b_act), 32'(eact));
            chk($sformatf("b_ready[%0d]", k), 32'(b_ready), 32'(erdy));
        end

`ifdef TICK_SCHED_SQUARE_EN
        // ch3 R=4: sq[3] high 5 cycles, low 5, then cleared by disable.
        @(negedge cLocK); a_rst = 1'b0; a_valid = 1'b0;
        @(negedge cLocK); a_rst = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            logic [4:0] esq;
            @(negedge cLocK);
            a_valid = 1'b0;
            if (k == 0)  begin a_valid = 1'b1; a_ch = 3'd3; a_ratio = 8'd4; a_en = 1'b1; end
            if (k == 18) begin a_valid = 1'b1; a_ch = 3'd3; a_ratio = 8'd4; a_en = 1'b0; end
            @(posedge cLocK);
            #1;
            esq = '0;
            esq[3] = ((k >= 6) && (k < 11)) || ((k >= 16) && (k < 19));
            chk($sformatf("a_sq[%0d]", k), 32'(a_sq), 32'(esq));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel tick scheduler that shares one base prescaler among NCH programmable divider channels. Each channel emits a one-cycle enable strobe every (ratio+1)·PRESCALE clock cycles. The block sits between the configuration logic and the timed consumers (display refresh, debouncers, blink logic), replacing one free-running frequency divider per consumer. Channels are configured at run time through a valid/ready handshake; a small FSM applies each update atomically and restarts the channel phase.

## Interface
Parameters:
- NCH, 4, number of divider channels (2..8)
- DW, 8, width of each channel ratio register
- PRESCALE, 1, base-tick period in clock cycles (≥1); shared by all channels

Ports:
- cLocK  in  1  system clock; all logic on the rising edge
- Reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  block can accept a configuration this cycle
- cfg_ch  in  clog2(NCH)  target channel; values ≥NCH are accepted and ignored
- cfg_ratio  in  DW  compare value R; channel period = (R+1)·PRESCALE cycles
- cfg_en  in  1  1 = enable channel, 0 = disable channel
- tick  out  NCH  per-channel one-cycle strobe, registered
- ch_active  out  NCH  per-channel enable state, registered
- sq  out  NCH  per-channel square wave (present only with TICK_SCHED_SQUARE_EN)

## Operation
- FSM states: IDLE (no channel enabled), RUN (≥1 channel enabled), UPDATE (applying an accepted configuration).
- Reset (Reset=0 at an edge): state←IDLE; prescaler, all channel counters, ratios, ch_active, tick and sq←0.
- cfg_ready = 1 in IDLE and RUN, 0 in UPDATE. A transfer occurs at an edge where cfg_valid & cfg_ready. cfg_ch, cfg_ratio and cfg_en are latched, and the state moves to UPDATE.
- UPDATE lasts exactly one cycle. At its closing edge:
  - ratio[ch]←latched R, cnt[ch]←0, ch_active[ch]←cfg_en;
  - if cfg_en=0, also sq[ch]←0.
  - Next state is RUN if any ch_active bit is 1 after the write, otherwise IDLE.
- Prescaler:
  - Counts 0..PRESCALE-1 in RUN and UPDATE; held at 0 in IDLE.
  - base = (pre == PRESCALE-1); with PRESCALE=1, base is always 1.
- Channel i, at an edge with ch_active[i] & base, in any state other than the UPDATE write for channel i:
  - cnt[i]==ratio[i]: cnt[i]←0, tick[i]←1, sq[i] toggles.
  - otherwise: cnt[i]←cnt[i]+1, tick[i]←0.
- tick[i]←0 at every other edge.
- Counters are DW bits wide. cnt never exceeds ratio, so no wrap-around occurs. R=0 produces a tick on every base tick; R=2^DW-1 gives the maximum period.
- Simultaneous events:
  - An UPDATE write to channel i overrides that channel's tick at the same edge; tick[i] is 0 in the next cycle.
  - Other channels keep running undisturbed through UPDATE.
- Disabling a channel clears its count, so the next enable always starts from phase 0.
- Configuration with cfg_en=0 to an already-disabled channel stores the ratio only.
- Reset asserted mid-operation or mid-UPDATE discards the pending update; all outputs are 0 in the cycle after the reset edge.

## Timing
- Handshake accepted at edge E0; UPDATE applied at E1; cfg_ready is 0 between E0 and E1 and 1 again after E1.
- With PRESCALE=1 and ratio R: the first tick is high in the cycle after edge E(R+2), then one tick every R+1 cycles.
- With PRESCALE=P starting from IDLE: the first base tick occurs P edges after E1. The first channel tick follows (R+1) base ticks after E1.
- Back-to-back configuration: maximum throughput is one transfer every 2 cycles.
- ch_active is valid from the cycle after E1.
- tick is exactly one cycle wide for every R≥0 when PRESCALE≥2. For PRESCALE=1 and R=0, tick is held continuously high.

## Configuration
- TICK_SCHED_SQUARE_EN defined:
  - the sq port and its per-channel toggle flops exist;
  - sq[i] toggles on every tick[i], giving a 50 % duty wave with period 2·(R+1)·PRESCALE cycles;
  - sq[i] is cleared on reset and on disable.
- Not defined: the sq port and flops are absent; all other behaviour is identical.

## Test plan
- Reset held low 3 cycles while cfg_valid=1 → cfg_ready stays 1, tick=0, ch_active=0, no configuration applied; after release the state is IDLE.
- PRESCALE=1, configure ch0 R=3 en=1 at E0 → ch_active[0]=1 after E1; tick[0] pulses after E5, E9, E13…; cfg_ready=0 for exactly one cycle.
- PRESCALE=4, ch1 R=1 → tick[1] period 8 cycles. Reconfigure ch1 R=0 mid-count → the old phase is discarded; new period is 4 cycles, with the first tick 4 edges after the UPDATE edge.
- ch0 R=2 running; configure ch2 at the edge where ch0 fires → ch0 ticks on schedule; a write to ch0 at its firing edge suppresses that tick.
- Disable the only active channel → state returns to IDLE, prescaler held at 0, tick and sq are 0; cfg_ch=NCH leaves all channels unchanged.
- With TICK_SCHED_SQUARE_EN, ch3 R=4, PRESCALE=1 → sq[3] high 5 cycles and low 5 cycles; disabling forces sq[3]=0 on the next cycle.
